// File: rtl/serdesphy_bringup_seq.sv
// SerDes PHY bring-up sequencer: power-up write/poll sequence onto the CSR bus,
// with host passthrough whenever no sequence is running.
module serdesphy_bringup_seq #(
   parameter logic [3:0] VCO_TRIM      = 4'h8,
   parameter logic [1:0] CP_CURRENT    = 2'h2,
   parameter logic [2:0] CDR_GAIN      = 3'h4,
   parameter logic [7:0] TX_CFG        = 8'h07,
   parameter logic [7:0] RX_CFG        = 8'h07,
   parameter int         RST_CYCLES    = 16,
   parameter int         POLL_INTERVAL = 8,
   parameter int         LOCK_TIMEOUT  = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seq_start,
   input  logic       seq_abort,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_wdata,
   input  logic       host_write_en,
   input  logic       host_read_en,
   output logic [7:0] host_rdata,
   output logic [7:0] csr_addr,
   output logic [7:0] csr_wdata,
   output logic       csr_write_en,
   output logic       csr_read_en,
   input  logic [7:0] csr_rdata,
   output logic       seq_busy,
   output logic       seq_done,
   output logic       seq_error,
   output logic [1:0] seq_err_code,
   output logic       host_drop
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_W_PHY     = 4'd1;
   localparam logic [3:0] S_W_PLL_RST = 4'd2;
   localparam logic [3:0] S_PLL_HOLD  = 4'd3;
   localparam logic [3:0] S_W_PLL_REL = 4'd4;
   localparam logic [3:0] S_PLL_POLL  = 4'd5;
   localparam logic [3:0] S_W_CDR_RST = 4'd6;
   localparam logic [3:0] S_W_CDR_REL = 4'd7;
   localparam logic [3:0] S_CDR_POLL  = 4'd8;
   localparam logic [3:0] S_W_CDR_RUN = 4'd9;
   localparam logic [3:0] S_W_TX      = 4'd10;
   localparam logic [3:0] S_W_RX      = 4'd11;
   localparam logic [3:0] S_DONE      = 4'd12;
   localparam logic [3:0] S_W_SAFE    = 4'd13;
   localparam logic [3:0] S_ERROR     = 4'd14;

   localparam logic [1:0] P_RD  = 2'd0;
   localparam logic [1:0] P_CHK = 2'd1;
   localparam logic [1:0] P_GAP = 2'd2;

   localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(POLL_INTERVAL - 1);
   localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);

   logic [3:0]  r_state, w_nxt;
   logic [1:0]  r_sub;
   logic [15:0] r_cnt, r_tmo;
   logic [1:0]  r_pend, w_pend;
   logic        r_done, r_error;
   logic [1:0]  r_code;
   logic        w_idle, w_poll, w_lock, w_start, w_abort;
   logic        w_wr, w_rd;
   logic [7:0]  w_waddr, w_wdata;

   assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE) ||
                    (r_state == S_ERROR);
   assign w_poll  = (r_state == S_PLL_POLL) || (r_state == S_CDR_POLL);
   assign w_lock  = (r_state == S_PLL_POLL) ? csr_rdata[0] : csr_rdata[1];
   assign w_start = seq_start & ~seq_abort & w_idle;
   assign w_abort = seq_abort & ~w_idle;
   assign w_rd    = w_poll && (r_sub == P_RD);

   always_comb begin
      w_wr    = 1'b1;
      w_waddr = 8'h00;
      w_wdata = 8'h00;
      case (r_state)
         S_W_PHY:     w_wdata = 8'h01;
         S_W_PLL_RST: begin w_waddr = 8'h04; w_wdata = {2'b01, CP_CURRENT, VCO_TRIM}; end
         S_W_PLL_REL: begin w_waddr = 8'h04; w_wdata = {2'b00, CP_CURRENT, VCO_TRIM}; end
         S_W_CDR_RST: begin w_waddr = 8'h05; w_wdata = {5'b00011, CDR_GAIN}; end
         S_W_CDR_REL: begin w_waddr = 8'h05; w_wdata = {5'b00001, CDR_GAIN}; end
         S_W_CDR_RUN: begin w_waddr = 8'h05; w_wdata = {5'b00000, CDR_GAIN}; end
         S_W_TX:      begin w_waddr = 8'h01; w_wdata = TX_CFG; end
         S_W_RX:      begin w_waddr = 8'h02; w_wdata = RX_CFG; end
         S_W_SAFE:    w_wdata = 8'h02;
         default:     w_wr = 1'b0;
      endcase
   end

   always_comb begin
      w_nxt  = r_state;
      w_pend = r_pend;
      if (w_abort) begin
         w_nxt  = S_W_SAFE;
         w_pend = 2'b11;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (w_start) w_nxt = S_W_PHY;
            S_W_PHY:     w_nxt = S_W_PLL_RST;
            S_W_PLL_RST: w_nxt = S_PLL_HOLD;
            S_PLL_HOLD:  if (r_cnt == HOLD_LAST) w_nxt = S_W_PLL_REL;
            S_W_PLL_REL: w_nxt = S_PLL_POLL;
            S_PLL_POLL, S_CDR_POLL: begin
               if (r_sub == P_CHK && w_lock) begin
                  w_nxt = (r_state == S_PLL_POLL) ? S_W_CDR_RST : S_W_CDR_RUN;
               end else if (r_tmo == TMO_LAST) begin
                  w_nxt  = S_W_SAFE;
                  w_pend = (r_state == S_PLL_POLL) ? 2'b01 : 2'b10;
               end
            end
            S_W_CDR_RST: w_nxt = S_W_CDR_REL;
            S_W_CDR_REL: w_nxt = S_CDR_POLL;
            S_W_CDR_RUN: w_nxt = S_W_TX;
            S_W_TX:      w_nxt = S_W_RX;
            S_W_RX:      w_nxt = S_DONE;
            S_W_SAFE:    w_nxt = S_ERROR;
            default:     w_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sub   <= P_RD;
         r_cnt   <= 16'd0;
         r_tmo   <= 16'd0;
         r_pend  <= 2'b00;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_code  <= 2'b00;
      end else begin
         r_state <= w_nxt;
         r_pend  <= w_pend;
         if (w_nxt != r_state) begin
            r_cnt <= 16'd0;
            r_tmo <= 16'd0;
            r_sub <= P_RD;
         end else if (w_poll) begin
            r_tmo <= r_tmo + 16'd1;
            case (r_sub)
               P_RD:  r_sub <= P_CHK;
               P_CHK: begin r_sub <= P_GAP; r_cnt <= 16'd0; end
               default: begin
                  if (r_cnt == GAP_LAST) r_sub <= P_RD;
                  else r_cnt <= r_cnt + 16'd1;
               end
            endcase
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
         // Status flags change only on entry to a terminal state or on restart
         if (w_start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= 2'b00;
         end else if (r_state == S_W_RX && w_nxt == S_DONE) begin
            r_done <= 1'b1;
         end else if (r_state == S_W_SAFE && w_nxt == S_ERROR) begin
            r_error <= 1'b1;
            r_code  <= r_pend;
         end
      end
   end

   assign csr_write_en = w_idle ? host_write_en : w_wr;
   assign csr_read_en  = w_idle ? host_read_en : w_rd;
   assign csr_addr     = w_idle ? host_addr : (w_waddr | (w_rd ? 8'h06 : 8'h00));
   assign csr_wdata    = w_idle ? host_wdata : w_wdata;
   assign host_rdata   = csr_rdata;
   assign host_drop    = ~w_idle & (host_write_en | host_read_en);
   assign seq_busy     = ~w_idle;
   assign seq_done     = r_done;
   assign seq_error    = r_error;
   assign seq_err_code = r_code;
endmodule

// File: tb/tb_serdesphy_bringup_seq.sv
// Directed bench for serdesphy_bringup_seq with a small CSR/status model
// and a log of every write seen on the CSR bus.
module tb_serdesphy_bringup_seq;
   localparam int RST_CYC = 16;
   localparam int PI      = 8;
   localparam int LT      = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       seq_start = 1'b0, seq_abort = 1'b0;
   logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
   logic       host_write_en = 1'b0, host_read_en = 1'b0;
   logic [7:0] host_rdata, csr_addr, csr_wdata, csr_rdata;
   logic       csr_write_en, csr_read_en;
   logic       seq_busy, seq_done, seq_error, host_drop;
   logic [1:0] seq_err_code;

   int checks = 0;
   int failures = 0;

   serdesphy_bringup_seq dut (
      .clk(clk), .rst(rst), .seq_start(seq_start), .seq_abort(seq_abort),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_write_en(host_write_en), .host_read_en(host_read_en),
      .host_rdata(host_rdata), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_write_en(csr_write_en), .csr_read_en(csr_read_en),
      .csr_rdata(csr_rdata), .seq_busy(seq_busy), .seq_done(seq_done),
      .seq_error(seq_error), .seq_err_code(seq_err_code),
      .host_drop(host_drop)
   );

   always #5 clk = ~clk;

   // CSR model: lock bits appear a fixed delay after the release writes
   int         cyc = 0;
   logic       pll_en = 1'b1, cdr_en = 1'b1;
   logic       pll_arm = 1'b0, cdr_arm = 1'b0;
   int         pll_at = 0, cdr_at = 0;
   logic       pll_lock, cdr_lock;
   logic [7:0] r_rdata = 8'h00;
   logic [7:0] la[$], ld[$];
   int         lc[$];

   assign pll_lock  = pll_en && pll_arm && (cyc >= pll_at);
   assign cdr_lock  = cdr_en && cdr_arm && (cyc >= cdr_at);
   assign csr_rdata = r_rdata;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (csr_read_en)
         r_rdata <= (csr_addr == 8'h06) ? {6'b0, cdr_lock, pll_lock} : 8'hA5;
      if (csr_write_en) begin
         la.push_back(csr_addr);
         ld.push_back(csr_wdata);
         lc.push_back(cyc);
         if (csr_addr == 8'h00 && csr_wdata == 8'h01) begin
            pll_arm <= 1'b0;
            cdr_arm <= 1'b0;
         end
         if (csr_addr == 8'h04 && csr_wdata == 8'h28) begin
            pll_arm <= 1'b1;
            pll_at  <= cyc + 100;
         end
         if (csr_addr == 8'h05 && csr_wdata == 8'h0C) begin
            cdr_arm <= 1'b1;
            cdr_at  <= cyc + 50;
         end
      end
   end

   logic [7:0] exp_a [8] = '{8'h00, 8'h04, 8'h04, 8'h05, 8'h05, 8'h05, 8'h01, 8'h02};
   logic [7:0] exp_d [8] = '{8'h01, 8'h68, 8'h28, 8'h1C, 8'h0C, 8'h04, 8'h07, 8'h07};

   task automatic pulse_start();
      @(negedge clk);
      seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while (seq_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (seq_busy) begin
         failures++;
         $display("FAIL %s: still busy after %0d cycles, required idle", nm, budget);
      end
   endtask

   task automatic wait_log(input int n, input int budget, input string nm);
      int k = 0;
      while (la.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (la.size() < n) begin
         failures++;
         $display("FAIL %s: write count %0d, required %0d", nm, la.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({seq_busy, seq_done, seq_error, seq_err_code, host_drop} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 000000",
                  {seq_busy, seq_done, seq_error, seq_err_code, host_drop});
      end
      host_addr = 8'h33; host_wdata = 8'h44; host_write_en = 1'b1;
      #1;
      checks++;
      if ({csr_write_en, csr_addr, csr_wdata} !== {1'b1, 8'h33, 8'h44}) begin
         failures++;
         $display("FAIL reset_passthrough: got %b/%h/%h required 1/33/44",
                  csr_write_en, csr_addr, csr_wdata);
      end
      @(negedge clk);
      host_write_en = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
   endtask

   task automatic test_start_abort_idle();
      int base = la.size();
      @(negedge clk);
      seq_start = 1'b1; seq_abort = 1'b1;
      @(negedge clk);
      seq_start = 1'b0; seq_abort = 1'b0;
      @(negedge clk);
      checks++;
      if ({seq_busy, seq_error, seq_done} !== 3'b000 || la.size() != base) begin
         failures++;
         $display("FAIL start_abort_idle: busy/err/done=%b writes=%0d required 000/0",
                  {seq_busy, seq_error, seq_done}, la.size() - base);
      end
   endtask

   task automatic test_nominal();
      int base = la.size();
      pll_en = 1'b1; cdr_en = 1'b1;
      pulse_start();
      wait_idle(2000, "nominal_wait");
      checks++;
      if (la.size() - base != 8) begin
         failures++;
         $display("FAIL nominal_count: got %0d writes required 8", la.size() - base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (la[base+i] !== exp_a[i] || ld[base+i] !== exp_d[i]) begin
               failures++;
               $display("FAIL nominal_write%0d: got %h=%h required %h=%h",
                        i, la[base+i], ld[base+i], exp_a[i], exp_d[i]);
            end
         end
         checks++;
         if (lc[base+2] - lc[base+1] != RST_CYC + 1) begin
            failures++;
            $display("FAIL nominal_hold: got %0d cycles required %0d",
                     lc[base+2] - lc[base+1], RST_CYC + 1);
         end
      end
      checks++;
      if ({seq_done, seq_error, seq_err_code} !== 4'b1000) begin
         failures++;
         $display("FAIL nominal_flags: got done/err/code %b required 1000",
                  {seq_done, seq_error, seq_err_code});
      end
   endtask

   task automatic test_pll_timeout();
      int base = la.size();
      int n, poll;
      pll_en = 1'b0; cdr_en = 1'b1;
      pulse_start();
      wait_idle(LT + 500, "pll_to_wait");
      n = la.size();
      checks++;
      if ({seq_error, seq_err_code, seq_done} !== 4'b1010) begin
         failures++;
         $display("FAIL pll_to_flags: got err/code/done %b required 1010",
                  {seq_error, seq_err_code, seq_done});
      end
      checks++;
      if (n - base != 4 || la[n-1] !== 8'h00 || ld[n-1] !== 8'h02) begin
         failures++;
         $display("FAIL pll_to_safe: %0d writes last %h=%h required 4 writes last 00=02",
                  n - base, la[n-1], ld[n-1]);
      end else begin
         poll = lc[n-1] - lc[n-2] - 1;
         checks++;
         if (poll < LT - PI - 2 || poll > LT + PI + 2) begin
            failures++;
            $display("FAIL pll_to_time: polled %0d cycles required %0d +/- %0d",
                     poll, LT, PI + 2);
         end
      end
      for (int i = base; i < n; i++) begin
         checks++;
         if (la[i] === 8'h05) begin
            failures++;
            $display("FAIL pll_to_no05: got write 05=%h required none", ld[i]);
         end
      end
   endtask

   task automatic test_cdr_timeout();
      int base = la.size();
      int n;
      pll_en = 1'b1; cdr_en = 1'b0;
      pulse_start();
      wait_idle(LT + 800, "cdr_to_wait");
      n = la.size();
      checks++;
      if ({seq_error, seq_err_code, seq_done} !== 4'b1100) begin
         failures++;
         $display("FAIL cdr_to_flags: got err/code/done %b required 1100",
                  {seq_error, seq_err_code, seq_done});
      end
      checks++;
      if (la[n-1] !== 8'h00 || ld[n-1] !== 8'h02 || n - base != 6) begin
         failures++;
         $display("FAIL cdr_to_safe: %0d writes last %h=%h required 6 last 00=02",
                  n - base, la[n-1], ld[n-1]);
      end
      for (int i = base; i < n; i++) begin
         checks++;
         if (la[i] === 8'h01 || la[i] === 8'h02) begin
            failures++;
            $display("FAIL cdr_to_notxrx: got write %h=%h required none", la[i], ld[i]);
         end
      end
   endtask

   task automatic test_abort_hold();
      int base = la.size();
      pll_en = 1'b1; cdr_en = 1'b1;
      pulse_start();
      wait_log(base + 2, 20, "abort_reach_hold");
      seq_abort = 1'b1;
      @(negedge clk);
      seq_abort = 1'b0;
      checks++;
      if ({seq_busy, csr_write_en, csr_addr, csr_wdata} !== {2'b11, 8'h00, 8'h02}) begin
         failures++;
         $display("FAIL abort_safe: got busy/we/addr/data %b/%b/%h/%h required 1/1/00/02",
                  seq_busy, csr_write_en, csr_addr, csr_wdata);
      end
      @(negedge clk);
      checks++;
      if ({seq_busy, seq_error, seq_err_code} !== 4'b0111) begin
         failures++;
         $display("FAIL abort_flags: got busy/err/code %b required 0111",
                  {seq_busy, seq_error, seq_err_code});
      end
   endtask

   task automatic test_host_drop();
      int base = la.size();
      int n;
      logic bad = 1'b0;
      pll_en = 1'b1; cdr_en = 1'b1;
      pulse_start();
      wait_log(base + 5, 400, "drop_reach_cdr");
      repeat (3) @(negedge clk);
      host_addr = 8'h07; host_wdata = 8'h05; host_write_en = 1'b1;
      #1;
      checks++;
      if (host_drop !== 1'b1 || csr_write_en !== 1'b0 || csr_wdata === 8'h05) begin
         failures++;
         $display("FAIL drop_busy: got drop/we/data %b/%b/%h required 1/0/not 05",
                  host_drop, csr_write_en, csr_wdata);
      end
      @(negedge clk);
      host_write_en = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
      #1;
      checks++;
      if (host_drop !== 1'b0) begin
         failures++;
         $display("FAIL drop_pulse: got %b required 0", host_drop);
      end
      wait_idle(400, "drop_wait");
      n = la.size();
      for (int i = base; i < n; i++) if (la[i] === 8'h07) bad = 1'b1;
      checks++;
      if (bad || n - base != 8 || seq_done !== 1'b1) begin
         failures++;
         $display("FAIL drop_seq: leaked=%b writes=%0d done=%b required 0/8/1",
                  bad, n - base, seq_done);
      end
      @(negedge clk);
      host_addr = 8'h07; host_wdata = 8'h05; host_write_en = 1'b1;
      #1;
      checks++;
      if ({host_drop, csr_write_en, csr_addr, csr_wdata} !== {2'b01, 8'h07, 8'h05}) begin
         failures++;
         $display("FAIL drop_pass: got drop/we/addr/data %b/%b/%h/%h required 0/1/07/05",
                  host_drop, csr_write_en, csr_addr, csr_wdata);
      end
      @(negedge clk);
      host_write_en = 1'b0; host_read_en = 1'b1; host_addr = 8'h06;
      @(negedge clk);
      host_read_en = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
      checks++;
      if (host_rdata !== 8'h03) begin
         failures++;
         $display("FAIL host_read: got %h required 03", host_rdata);
      end
   endtask

   task automatic test_rst_restart();
      int base = la.size();
      int n;
      pll_en = 1'b1; cdr_en = 1'b1;
      pulse_start();
      wait_log(base + 3, 40, "rst_reach_poll");
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = la.size();
      checks++;
      if ({seq_busy, seq_done, seq_error, seq_err_code, host_drop,
           csr_write_en, csr_read_en} !== 8'b0 || n - base != 3) begin
         failures++;
         $display("FAIL rst_mid: got outs %b writes=%0d required 00000000/3",
                  {seq_busy, seq_done, seq_error, seq_err_code, host_drop,
                   csr_write_en, csr_read_en}, n - base);
      end
      for (int r = 0; r < 2; r++) begin
         base = la.size();
         pulse_start();
         wait_idle(2000, "restart_wait");
         checks++;
         if (la.size() - base != 8 || seq_done !== 1'b1) begin
            failures++;
            $display("FAIL restart%0d_count: writes=%0d done=%b required 8/1",
                     r, la.size() - base, seq_done);
         end else begin
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (la[base+i] !== exp_a[i] || ld[base+i] !== exp_d[i]) begin
                  failures++;
                  $display("FAIL restart%0d_write%0d: got %h=%h required %h=%h",
                           r, i, la[base+i], ld[base+i], exp_a[i], exp_d[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_abort_idle();
      test_nominal();
      test_pll_timeout();
      test_cdr_timeout();
      test_abort_hold();
      test_host_drop();
      test_rst_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
